// File: rtl/dac_frame_serializer_prep.sv
// dac_frame_serializer_prep: 125 MHz parallel-side framer for the DAC5681 LVDS path.
// Transposes eight 16-bit samples per cycle into sixteen 8-bit OSERDESE3 lane words.
// Also generates the DCLK/SYNC lane words, sequences the OSERDES reset, and counts underflow cycles.
// Optional feature macro: TWOS_COMP_EN. When defined, input samples are two's complement and
// are converted to offset binary by inverting each sample MSB. IDLE_CODE is never converted.
// Ports:
//   f125m_clk, rst_n             parallel clock, async active-low reset
//   s_tdata/s_tvalid/s_tready    sample stream; sample k in [16k+15:16k], sample 0 earliest
//   enable                       level request to stream
//   oser_rst                     OSERDESE3 reset, high while in HOLD
//   lane_data                    lane i in [8i+7:8i]; bit j = bit i of sample j
//   dclk_pattern, sync_pattern   DCLK / SYNC lane words
//   state                        0 HOLD, 1 IDLE, 2 SYNC, 3 RUN
//   underflow_cnt                saturating count of RUN cycles without a beat
module dac_frame_serializer_prep #(
  parameter int          OSER_RST_CYCLES = 16,
  parameter int          SYNC_CYCLES     = 4,
  parameter logic [15:0] IDLE_CODE       = 16'h8000
) (
  input  logic         f125m_clk,
  input  logic         rst_n,
  input  logic [127:0] s_tdata,
  input  logic         s_tvalid,
  output logic         s_tready,
  input  logic         enable,
  output logic         oser_rst,
  output logic [127:0] lane_data,
  output logic [7:0]   dclk_pattern,
  output logic [7:0]   sync_pattern,
  output logic [1:0]   state,
  output logic [15:0]  underflow_cnt
);
  typedef enum logic [1:0] {HOLD = 2'd0, IDLE = 2'd1, SYNC = 2'd2, RUN = 2'd3} state_t;

  function automatic logic [127:0] transpose(input logic [127:0] s);
    logic [127:0] t;
    t = '0;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 8; j++)
        t[8*i+j] = s[16*j+i];
    return t;
  endfunction

  localparam logic [127:0] IDLE_FRAME = transpose({8{IDLE_CODE}});

  state_t         r_state, w_next;
  logic [15:0]    r_cnt, w_cnt_next;
  logic           r_oser_rst;
  logic [127:0]   r_lane, w_beat;
  logic [7:0]     r_dclk, r_sync;
  logic [15:0]    r_ufl;

`ifdef TWOS_COMP_EN
  assign w_beat = s_tdata ^ {8{16'h8000}};
`else
  assign w_beat = s_tdata;
`endif

  assign s_tready      = (r_state == RUN);
  assign state         = r_state;
  assign oser_rst      = r_oser_rst;
  assign lane_data     = r_lane;
  assign dclk_pattern  = r_dclk;
  assign sync_pattern  = r_sync;
  assign underflow_cnt = r_ufl;

  // r_cnt counts HOLD cycles, then SYNC cycles; it is zero on entry to either state.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = '0;
    case (r_state)
      HOLD: begin
        w_next     = (r_cnt == 16'(OSER_RST_CYCLES - 1)) ? IDLE : HOLD;
        w_cnt_next = (r_cnt == 16'(OSER_RST_CYCLES - 1)) ? '0 : r_cnt + 16'd1;
      end
      IDLE: w_next = enable ? SYNC : IDLE;
      SYNC: begin
        w_next     = !enable ? IDLE : (r_cnt == 16'(SYNC_CYCLES - 1)) ? RUN : SYNC;
        w_cnt_next = (enable && r_cnt != 16'(SYNC_CYCLES - 1)) ? r_cnt + 16'd1 : '0;
      end
      RUN:  w_next = enable ? RUN : IDLE;
      default: w_next = HOLD;
    endcase
  end

  // Pattern outputs are registered from the next state so they change on the transition edge.
  always_ff @(posedge f125m_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= HOLD;
      r_cnt      <= '0;
      r_oser_rst <= 1'b1;
      r_lane     <= IDLE_FRAME;
      r_dclk     <= 8'h00;
      r_sync     <= 8'h00;
      r_ufl      <= '0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_next;
      r_oser_rst <= (w_next == HOLD);
      r_lane     <= (s_tready && s_tvalid) ? transpose(w_beat) : IDLE_FRAME;
      r_dclk     <= (w_next == HOLD) ? 8'h00 : 8'hAA;
      r_sync     <= (w_next == SYNC) ? 8'hFF : 8'h00;
      r_ufl      <= (r_state == IDLE && w_next == SYNC) ? '0 :
                    (s_tready && !s_tvalid && r_ufl != 16'hFFFF) ? r_ufl + 16'd1 : r_ufl;
    end
  end
endmodule

// File: tb/tb_dac_frame_serializer_prep.sv
// tb_dac_frame_serializer_prep: directed bench with a phase-level reference model of the framer.
module tb_dac_frame_serializer_prep;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [127:0] s_tdata = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic         enable = 1'b0;
  logic         oser_rst;
  logic [127:0] lane_data;
  logic [7:0]   dclk_pattern, sync_pattern;
  logic [1:0]   state;
  logic [15:0]  underflow_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit run_cmp = 1'b1;

  dac_frame_serializer_prep #(.OSER_RST_CYCLES(16), .SYNC_CYCLES(4), .IDLE_CODE(16'h8000)) dut (
    .f125m_clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .enable(enable), .oser_rst(oser_rst), .lane_data(lane_data), .dclk_pattern(dclk_pattern),
    .sync_pattern(sync_pattern), .state(state), .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Lane words built sample by sample: lane i collects bit i of every sample, sample j landing in bit j.
  function automatic logic [127:0] lanes_of(input logic [127:0] d, input bit conv);
    logic [7:0]   lane [16];
    logic [15:0]  smp;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) lane[i] = 8'h00;
    for (int j = 0; j < 8; j++) begin
      smp = d[16*j +: 16];
`ifdef TWOS_COMP_EN
      if (conv) smp = smp ^ 16'h8000;
`endif
      for (int i = 0; i < 16; i++) lane[i] = lane[i] | (8'(smp[i]) << j);
    end
    for (int i = 0; i < 16; i++) r[8*i +: 8] = lane[i];
    return r;
  endfunction

  // Reference model: a mode number plus a cycles-remaining counter for the timed phases.
  int           m_mode, m_left, m_ufl;
  logic [127:0] m_lane;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_left = 16; m_ufl = 0; m_lane = lanes_of({8{16'h8000}}, 1'b0);
    end else begin
      m_lane = lanes_of({8{16'h8000}}, 1'b0);
      case (m_mode)
        0: begin m_left--; if (m_left == 0) m_mode = 1; end
        1: if (enable) begin m_mode = 2; m_left = 4; m_ufl = 0; end
        2: if (!enable) m_mode = 1; else begin m_left--; if (m_left == 0) m_mode = 3; end
        default: begin
          if (s_tvalid) m_lane = lanes_of(s_tdata, 1'b1);
          else if (m_ufl < 65535) m_ufl++;
          if (!enable) m_mode = 1;
        end
      endcase
    end
  end

  always @(negedge clk) if (run_cmp) begin
    chk("state", 128'(state), 128'(m_mode[1:0]));
    chk("oser_rst", 128'(oser_rst), 128'(m_mode == 0));
    chk("dclk_pattern", 128'(dclk_pattern), (m_mode == 0) ? 128'h00 : 128'hAA);
    chk("sync_pattern", 128'(sync_pattern), (m_mode == 2) ? 128'hFF : 128'h00);
    chk("s_tready", 128'(s_tready), 128'(m_mode == 3));
    chk("lane_data", lane_data, m_lane);
    chk("underflow_cnt", 128'(underflow_cnt), 128'(m_ufl));
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic hold_sequence();
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("hold_oser_rst_k%0d", k), 128'(oser_rst), 128'(k < 16));
    end
    chk("idle_state", 128'(state), 128'd1);
    chk("idle_dclk", 128'(dclk_pattern), 128'hAA);
  endtask

  task automatic enter_run();
    int n_sync;
    n_sync = 0;
    enable = 1'b1;
    repeat (5) begin tick(); if (sync_pattern == 8'hFF) n_sync++; end
    chk("sync_cycle_count", 128'(n_sync), 128'd4);
    chk("run_state", 128'(state), 128'd3);
    chk("run_tready", 128'(s_tready), 128'd1);
  endtask

  localparam logic [127:0] IDLE_LIT  = {8'hFF, 120'h0};
  localparam logic [127:0] SHIFT_LIT = 128'h0000_0000_0000_0000_8040_2010_0804_0201;
`ifdef TWOS_COMP_EN
  localparam logic [127:0] ZERO_LIT = {8'hFF, 120'h0};
  localparam logic [127:0] ONES_LIT = {8'h00, {120{1'b1}}};
`else
  localparam logic [127:0] ZERO_LIT = 128'h0;
  localparam logic [127:0] ONES_LIT = {128{1'b1}};
`endif

  logic [127:0] tbl_data [6] = '{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                                 128'hA5A5_5A5A_FFFF_0000_1234_8000_7FFF_0001,
                                 128'hDEAD_BEEF_CAFE_F00D_0BAD_C0DE_FACE_B00C,
                                 128'h8000_8000_8000_8000_8000_8000_8000_8000,
                                 128'h0F0F_F0F0_3C3C_C3C3_5555_AAAA_0000_FFFF,
                                 128'h1111_2222_4444_8888_1357_9BDF_2468_ACE0};
  bit tbl_valid [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    logic [127:0] d;
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("reset_state", 128'(state), 128'd0);
    chk("reset_oser_rst", 128'(oser_rst), 128'd1);
    chk("reset_tready", 128'(s_tready), 128'd0);
    chk("reset_lane_idle", lane_data, IDLE_LIT);
    rst_n = 1'b1;
    hold_sequence();
    tick();
    enter_run();
    for (int j = 0; j < 8; j++) d[16*j +: 16] = 16'h0001 << j;
    s_tdata = d; s_tvalid = 1'b1;
    tick();
    chk("shift_beat_lanes", lane_data, SHIFT_LIT);
    s_tvalid = 1'b0;
    repeat (3) tick();
    chk("underflow_lanes", lane_data, IDLE_LIT);
    chk("underflow_cnt3", 128'(underflow_cnt), 128'd3);
    s_tdata = '0; s_tvalid = 1'b1;
    tick();
    chk("zero_beat_lanes", lane_data, ZERO_LIT);
    for (int t = 0; t < 6; t++) begin
      s_tdata = tbl_data[t]; s_tvalid = tbl_valid[t];
      tick();
    end
    s_tdata = {128{1'b1}}; s_tvalid = 1'b1; enable = 1'b0;
    tick();
    chk("exit_edge_lanes", lane_data, ONES_LIT);
    chk("exit_state", 128'(state), 128'd1);
    s_tvalid = 1'b0; enable = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    chk("sync_abort_state", 128'(state), 128'd1);
    chk("sync_abort_ufl_clear", 128'(underflow_cnt), 128'd0);
    tick();
    enter_run();
    s_tvalid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_oser", 128'(oser_rst), 128'd1);
    chk("midrun_reset_state", 128'(state), 128'd0);
    chk("midrun_reset_ufl", 128'(underflow_cnt), 128'd0);
    chk("midrun_reset_tready", 128'(s_tready), 128'd0);
    tick();
    enable = 1'b0;
    rst_n = 1'b1;
    hold_sequence();
    tick();
    run_cmp = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
